lif_scheduler: RTL and testbench
================================

LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, meaning number of time-multiplexed neurons (2..16).
REQ-002 SHALL have parameter THRESHOLD, default 128, meaning 8-bit firing threshold (1..255).
REQ-003 SHALL have parameter WEIGHT, default 64, meaning 8-bit synaptic current injected into neuron i when neuron i-1 spikes in the same timestep.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port current, input, 8, external input current to neuron 0.
REQ-007 SHALL have port beta, input, 3, decay shift amount.
REQ-008 SHALL have port start, input, 1, request for one timestep.
REQ-009 SHALL have port busy, output, 1, high while a timestep is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at the end of a timestep.
REQ-011 SHALL have port spikes, output, N_NEURONS, spike vector of the last completed timestep.
REQ-012 SHALL have port rd_idx, input, clog2(N_NEURONS), membrane read select.
REQ-013 SHALL have port rd_data, output, 8, combinational membrane value of neuron rd_idx.

Function
REQ-014 SHALL implement FSM IDLE -> UPDATE -> DONE -> IDLE with one shared 8-bit update datapath and an N_NEURONS x 8 membrane register file.
REQ-015 SHALL, in IDLE, accept start=1 at edge E0: latch current and beta, clear index, enter UPDATE; busy=1 from E0 until the DONE->IDLE edge.
REQ-016 SHALL, in UPDATE, update neuron idx at edges E1..EN (one per cycle, idx 0..N_NEURONS-1), then enter DONE.
REQ-017 SHALL compute per neuron: decay = mem >> beta; in = latched current (idx 0) or WEIGHT if spike[idx-1] of this timestep else 0 (idx>0); sum = decay + in, saturated to 255.
REQ-018 SHALL, if sum >= THRESHOLD, set spike[idx]=1 and store sum - THRESHOLD; else set spike[idx]=0 and store sum.
REQ-019 SHALL hold a working spike vector internally; copy it to spikes at the edge entering DONE; spikes stable otherwise.
REQ-020 SHALL assert done for exactly the single DONE cycle (N_NEURONS cycles after E0) and return to IDLE on the next edge.
REQ-021 SHALL ignore start while busy=1 or in DONE; no queuing.
REQ-022 SHALL hold current/beta changes during UPDATE without effect (latched values used).
REQ-023 SHALL return rd_data = 0 for rd_idx >= N_NEURONS.

Reset
REQ-024 SHALL on rst=1, immediately and regardless of state: FSM to IDLE, idx=0, all membranes 0, spikes=0, busy=0, done=0.
REQ-025 SHALL discard a partially completed timestep on reset mid-UPDATE; no done pulse is produced.

Configuration
REQ-026 SHALL support macro LIF_REFRACTORY_EN: when defined, a neuron whose spikes bit was 1 in the previous completed timestep stores 0, outputs spike 0 and ignores its input for this timestep; when undefined, no refractory behaviour, per REQ-017/018 only.

Verification (N_NEURONS=4, THRESHOLD=128, WEIGHT=64, macro undefined unless stated)
REQ-027 Assert rst mid-UPDATE -> busy, done, spikes, all rd_data = 0 immediately; no done pulse follows.
REQ-028 From reset, current=200, beta=1, start -> done exactly 4 cycles after accepting edge; spikes=4'b0001; mem0=72, mem1=64, mem2=0, mem3=0.
REQ-029 Then current=0, beta=1, start -> spikes=4'b0000; mem0=36, mem1=32.
REQ-030 mem0=127, current=255, beta=0, start -> sum saturates to 255; spike[0]=1; mem0=127; mem1=64.
REQ-031 start held high through entire timestep -> exactly one timestep executed, one done pulse; next accepted only from IDLE.
REQ-032 LIF_REFRACTORY_EN defined: REQ-028 then current=200 again -> spikes=4'b0000, mem0=0.

Source files
------------

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one shared 8-bit update datapath walks
// N_NEURONS membranes per timestep. Optional refractory behaviour via `define LIF_REFRACTORY_EN.
module lif_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int THRESHOLD = 128,
  parameter int WEIGHT    = 64,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           current,
  input  logic [2:0]           beta,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes,
  input  logic [IW-1:0]        rd_idx,
  output logic [7:0]           rd_data,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled only in IDLE; busy covers UPDATE and DONE;
  // done is a one-cycle pulse in DONE, and spikes are valid from that cycle on.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [7:0]    TH8  = 8'(THRESHOLD);
  localparam logic [7:0]    W8   = 8'(WEIGHT);
  localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

  state_t               state, state_n;
  logic [IW-1:0]        idx;
  logic [7:0]           cur_q;
  logic [2:0]           beta_q;
  logic [7:0]           mem [N_NEURONS];
  logic [N_NEURONS-1:0] work_spk, work_next;

  logic [7:0] mem_cur, decay, inj, sum_sat, new_mem;
  logic [8:0] sum9;
  logic       fire;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_UPDATE;
      S_UPDATE: if (idx == LAST) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Shared per-neuron update; the input of neuron idx>0 comes from this timestep's spike of idx-1.
  always_comb begin
    mem_cur = mem[idx];
    decay   = mem_cur >> beta_q;
    if (idx == '0)                   inj = cur_q;
    else if (work_spk[idx - IW'(1)]) inj = W8;
    else                             inj = 8'd0;
    sum9    = {1'b0, decay} + {1'b0, inj};
    sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
    fire    = (sum_sat >= TH8);
    new_mem = fire ? (sum_sat - TH8) : sum_sat;
`ifdef LIF_REFRACTORY_EN
    if (spikes[idx]) begin
      fire    = 1'b0;
      new_mem = 8'd0;
    end
`endif
    work_next      = work_spk;
    work_next[idx] = fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      cur_q    <= '0;
      beta_q   <= '0;
      work_spk <= '0;
      spikes   <= '0;
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_q    <= current;
            beta_q   <= beta;
            idx      <= '0;
            work_spk <= '0;
          end
        end
        S_UPDATE: begin
          mem[idx] <= new_mem;
          work_spk <= work_next;
          if (idx == LAST) spikes <= work_next;
          else             idx    <= idx + IW'(1);
        end
        default: idx <= '0;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'd0;
    if (int'(rd_idx) < N_NEURONS) rd_data = mem[rd_idx];
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Bench for lif_scheduler: directed timestep table, multi-cycle corner sequences,
// and randomized timesteps checked against an arithmetic reference model.
module tb_lif_scheduler;
  localparam int N  = 4;
  localparam int TH = 128;
  localparam int W  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   current;
  logic [2:0]   beta;
  logic         start;
  logic         busy, done;
  logic [N-1:0] spikes;
  logic [1:0]   rd_idx;
  logic [7:0]   rd_data;
  logic [1:0]   dbg_state;

  lif_scheduler #(.N_NEURONS(N), .THRESHOLD(TH), .WEIGHT(W)) dut (
    .clk(clk), .rst(rst), .current(current), .beta(beta), .start(start),
    .busy(busy), .done(done), .spikes(spikes), .rd_idx(rd_idx),
    .rd_data(rd_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: membranes and last completed spike vector, updated per timestep.
  int           mdl_mem [N];
  logic [N-1:0] mdl_prev;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl_mem[i] = 0;
    mdl_prev = '0;
  endtask

  task automatic model_step(input int cur, input int b);
    logic [N-1:0] s;
    int           sum;
    s = '0;
    for (int i = 0; i < N; i++) begin
      sum = (mdl_mem[i] >> b) + ((i == 0) ? cur : (s[i-1] ? W : 0));
      if (sum > 255) sum = 255;
      if (sum >= TH) begin s[i] = 1'b1; mdl_mem[i] = sum - TH; end
      else mdl_mem[i] = sum;
`ifdef LIF_REFRACTORY_EN
      if (mdl_prev[i]) begin s[i] = 1'b0; mdl_mem[i] = 0; end
`endif
    end
    mdl_prev = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // One timestep: checks acceptance, latency to done, and the return to IDLE.
  // Current/beta are scrambled during UPDATE since only the latched values may count.
  task automatic run_timestep(input logic [7:0] cur, input logic [2:0] b, input bit scramble);
    int cycles;
    current = cur;
    beta    = b;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    cycles = 0;
    while (!done && cycles < 20) begin
      if (scramble) begin
        current = 8'($urandom_range(0, 255));
        beta    = 3'($urandom_range(0, 7));
      end
      step();
      cycles++;
    end
    check("done_latency", cycles, N);
    step();
    check("idle_after_done", {30'd0, busy, done}, 0);
  endtask

  task automatic check_state(input string tag, input logic [N-1:0] exp_spk,
                             input logic [N-1:0][7:0] exp_mem);
    check({tag, "_spikes"}, 32'(spikes), 32'(exp_spk));
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s_mem%0d", tag, i), 32'(rd_data), 32'(exp_mem[i]));
    end
  endtask

  typedef struct {
    bit               do_rst;
    logic [7:0]       cur;
    logic [2:0]       b;
    logic [N-1:0]     exp_spk;
    logic [N-1:0][7:0] exp_mem;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [N-1:0][7:0] m;
    int n_done;
    logic [7:0] rc;
    logic [2:0] rb;

    // {mem3, mem2, mem1, mem0}
    vecs[0] = '{1'b1, 8'd200, 3'd1, 4'b0001, {8'd0, 8'd0, 8'd64, 8'd72}};
`ifdef LIF_REFRACTORY_EN
    vecs[1] = '{1'b0, 8'd200, 3'd1, 4'b0000, {8'd0, 8'd0, 8'd32, 8'd0}};
`else
    vecs[1] = '{1'b0, 8'd0,   3'd1, 4'b0000, {8'd0, 8'd0, 8'd32, 8'd36}};
`endif
    vecs[2] = '{1'b1, 8'd127, 3'd0, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd127}};
    vecs[3] = '{1'b0, 8'd255, 3'd0, 4'b0001, {8'd0, 8'd0, 8'd64, 8'd127}};
    vecs[4] = '{1'b1, 8'd255, 3'd0, 4'b0001, {8'd0, 8'd0, 8'd64, 8'd127}};
`ifdef LIF_REFRACTORY_EN
    vecs[5] = '{1'b0, 8'd255, 3'd0, 4'b0000, {8'd0, 8'd0, 8'd64, 8'd0}};
    vecs[6] = '{1'b0, 8'd255, 3'd0, 4'b0011, {8'd0, 8'd64, 8'd0, 8'd127}};
`else
    vecs[5] = '{1'b0, 8'd255, 3'd0, 4'b0011, {8'd0, 8'd64, 8'd0, 8'd127}};
    vecs[6] = '{1'b0, 8'd255, 3'd0, 4'b0001, {8'd0, 8'd64, 8'd64, 8'd127}};
`endif

    rst = 1'b0; current = '0; beta = '0; start = 1'b0; rd_idx = '0;
    step();
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_state("reset", '0, '0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_rst) do_reset();
      run_timestep(vecs[v].cur, vecs[v].b, 1'b0);
      check_state($sformatf("vec%0d", v), vecs[v].exp_spk, vecs[v].exp_mem);
    end

    // Reset in the middle of UPDATE: everything clears at once, no done follows.
    do_reset();
    run_timestep(8'd200, 3'd1, 1'b0);
    current = 8'd200; beta = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check_state("midrst", '0, '0);
    step();
    rst = 1'b0;
    model_reset();
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (done) n_done++;
    end
    check("midrst_no_done", n_done, 0);

    // start held high: one timestep only; the next can only be taken from IDLE.
    current = 8'd200; beta = 3'd1; start = 1'b1;
    step();
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (done) n_done++;
    end
    check("held_busy_low", busy, 0);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done) n_done++;
    end
    check("held_one_done", n_done, 1);
    model_step(200, 1);
    for (int i = 0; i < N; i++) m[i] = 8'(mdl_mem[i]);
    check_state("held", mdl_prev, m);

    // Randomized timesteps against the model, with inputs scrambled during UPDATE.
    do_reset();
    for (int t = 0; t < 24; t++) begin
      rc = 8'($urandom_range(0, 255));
      rb = 3'($urandom_range(0, 3));
      run_timestep(rc, rb, 1'b1);
      model_step(int'(rc), int'(rb));
      for (int i = 0; i < N; i++) m[i] = 8'(mdl_mem[i]);
      check_state($sformatf("rand%0d", t), mdl_prev, m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
